mio_bus_if: RTL and testbench
=============================

# mio_bus_if

Parametrised memory/IO bus sequencer between the multi-cycle CPU datapath and the MIO bus. It accepts one load or store request at a time and drives address, byte enables and aligned write data onto the bus. It holds the access until `MIO_ready`, with a programmable timeout. It then returns sub-word-extracted, sign/zero-extended read data with an error flag, so the CPU control FSM gains real wait-state, sub-word and bus-error support.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, bus data width; 32 or 64 only. `BYTES = DATA_W/8`, `LB = log2(BYTES)`.
- `TIMEOUT`, 255, maximum ACCESS cycles without `MIO_ready` before a bus error; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: CPU presents a request.
- `req_ready` out 1: block is idle; a request is accepted on `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- `req_signed` in 1: sign-extend load data (0 = zero-extend).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned, illegal size, or timeout; qualified by `rsp_valid`.
- `CPU_MIO` out 1: bus request, held for the whole ACCESS state.
- `mem_w` out 1: bus write strobe.
- `Addr_out` out ADDR_W: `req_addr` with the low LB bits cleared.
- `Data_out` out DATA_W: store data shifted into its byte lanes.
- `be_out` out BYTES: byte-lane enables.
- `Data_in` in DATA_W: bus read data.
- `MIO_ready` in 1: bus completion, sampled only in ACCESS.

## Operation
- FSM states are IDLE, ACCESS and RESP; the state is 2-bit and registered.
- **IDLE**
  - `req_ready`=1.
  - On acceptance, compute `lane = req_addr[LB-1:0]`.
  - Misaligned requests: half with lane[0]≠0, word with lane[1:0]≠0, dword with lane≠0. These go to RESP with error set and issue no bus cycle.
  - `req_size`=11 with DATA_W=32 is treated the same as a misaligned request.
  - Otherwise latch we/size/signed/lane/wdata and the aligned address, clear the wait counter, and go to ACCESS.
- **ACCESS**
  - Drives `CPU_MIO`=1, `mem_w`=latched we, `Addr_out`, `be_out` and `Data_out`.
  - `be_out = size_mask << lane`, where size_mask is 1, 3, F or FF.
  - `Data_out = wdata << (8*lane)`.
  - When `MIO_ready`=1, a load captures `Data_in >> (8*lane)`, truncated to the size and extended per signed. Then go to RESP with error cleared.
  - Otherwise the counter increments, saturating at TIMEOUT. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ready, go to RESP with error set and rdata=0.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then return to IDLE.
- Outside ACCESS, `CPU_MIO`, `mem_w` and `be_out` are 0; `Addr_out` and `Data_out` hold their last values.
- `rsp_rdata` and `rsp_err` are registered and hold until the next RESP.
- `req_valid` outside IDLE is ignored; the CPU holds the request until it is accepted.
- `MIO_ready` outside ACCESS is ignored.

## Timing
- Reset forces state IDLE and sets all registered outputs to 0. Consequently:
  - `req_ready`=1.
  - `rsp_valid`, `rsp_err` and `rsp_rdata` = 0.
  - `CPU_MIO`, `mem_w` and `be_out` = 0.
  - `Addr_out` and `Data_out` = 0.
- Accept at edge N, so ACCESS runs from N+1. Ready at the first ACCESS cycle puts RESP at N+2, and `req_ready` is back at N+3.
- Minimum accept-to-response latency is 2 cycles; each wait cycle adds 1.
- Misaligned or illegal requests give RESP at N+1 with no bus activity.
- Timeout: with no ready, RESP is entered after exactly TIMEOUT ACCESS cycles.
- If `MIO_ready` and timeout expiry occur in the same cycle, ready wins and the response carries no error.
- Reset during ACCESS or RESP aborts the transfer: no `rsp_valid`, and the bus signals drop asynchronously.
- Back-to-back throughput is one access per 3 cycles at zero wait states.

## Test plan
- **Load byte, sign-extended:** DATA_W=32, load byte signed at addr 0x1003, `Data_in`=0x80xxxxxx, ready on the first ACCESS cycle.
  - Bus: `Addr_out`=0x1000, `be_out`=1000.
  - Response: `rsp_rdata`=0xFFFFFF80, `rsp_err`=0, `rsp_valid` 2 cycles after accept.
- **Store half:** store half 0xBEEF at addr 0x2002 with 3 wait cycles.
  - Bus: `Data_out`=0xBEEF0000, `be_out`=1100, `mem_w`=1 for 4 cycles.
  - Response: `rsp_valid` 5 cycles after accept.
- **Misaligned word:** load word at 0x0001.
  - Response: `rsp_err`=1 with `rsp_valid` 1 cycle after accept.
  - Bus: `CPU_MIO` never asserts.
- **Timeout:** TIMEOUT=4, `MIO_ready` held 0.
  - `CPU_MIO` is high for exactly 4 cycles.
  - Response: `rsp_err`=1, `rsp_rdata`=0.
  - Rerun with ready arriving in the 4th cycle: `rsp_err`=0.
- **Dword load:** DATA_W=64, load dword unsigned at 0x8, `Data_in`=0x0123456789ABCDEF.
  - Bus: `be_out`=0xFF.
  - Response: `rsp_rdata` equals `Data_in`.
- **Reset mid-access:** assert reset during the 2nd ACCESS cycle.
  - All outputs go to 0 immediately, no `rsp_valid` is produced, and `req_ready`=1 after release.

Source files
------------

// File: rtl/mio_bus_if_if.sv
// CPU-side request/response and MIO bus signals of the memory/IO sequencer.
// "slave" is the sequencer's own view; "master" is the CPU plus bus environment.
interface mio_bus_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              CPU_MIO;
  logic              mem_w;
  logic [ADDR_W-1:0] Addr_out;
  logic [DATA_W-1:0] Data_out;
  logic [BYTES-1:0]  be_out;
  logic [DATA_W-1:0] Data_in;
  logic              MIO_ready;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, Data_in, MIO_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, CPU_MIO, mem_w, Addr_out, Data_out, be_out
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, Data_in, MIO_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, CPU_MIO, mem_w, Addr_out, Data_out, be_out
  );
endinterface

// File: rtl/mio_bus_if.sv
// Single-outstanding load/store sequencer onto the MIO bus: lane steering,
// wait states with timeout, sub-word extraction and sign/zero extension.
module mio_bus_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     reset,
  mio_bus_if_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cpu_mio_q, cpu_mio_d;
  logic              mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [BYTES-1:0]  be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [LB-1:0]     lane;
  int                req_nbytes, cur_nbits;
  logic              misaligned;
  logic [BYTES-1:0]  req_mask;
  logic [DATA_W-1:0] rd_shift, rd_ext;
  logic              rd_sign;

  function automatic int size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  // Request decode: lane, alignment and byte-lane mask for the incoming access.
  always_comb begin
    lane       = bus.req_addr[LB-1:0];
    req_nbytes = size_bytes(bus.req_size);
    misaligned = ((DATA_W == 32) && (bus.req_size == 2'b11)) ||
                 ((lane & LB'(req_nbytes - 1)) != '0);
    req_mask   = '0;
    for (int i = 0; i < BYTES; i++) req_mask[i] = (i < req_nbytes);
  end

  // Load path: right-align the addressed lanes, then extend above the access size.
  always_comb begin
    rd_shift  = bus.Data_in >> {lane_q, 3'b000};
    cur_nbits = 8 * size_bytes(size_q);
    case (size_q)
      2'b00:   rd_sign = rd_shift[7];
      2'b01:   rd_sign = rd_shift[15];
      2'b10:   rd_sign = rd_shift[31];
      default: rd_sign = rd_shift[DATA_W-1];
    endcase
    rd_ext = '0;
    for (int i = 0; i < DATA_W; i++)
      rd_ext[i] = (i < cur_nbits) ? rd_shift[i] : (signed_q & rd_sign);
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    cpu_mio_d   = cpu_mio_q;
    mem_w_d     = mem_w_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = ACCESS;
            we_d       = bus.req_we;
            size_d     = bus.req_size;
            signed_d   = bus.req_signed;
            lane_d     = lane;
            cnt_d      = '0;
            cpu_mio_d  = 1'b1;
            mem_w_d    = bus.req_we;
            addr_d     = {bus.req_addr[ADDR_W-1:LB], LB'(0)};
            data_out_d = bus.req_wdata << {lane, 3'b000};
            be_d       = req_mask << lane;
          end
        end
      end
      ACCESS: begin
        // Ready takes priority over a timeout expiring in the same cycle.
        if (bus.MIO_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : rd_ext;
          cpu_mio_d   = 1'b0;
          mem_w_d     = 1'b0;
          be_d        = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            cpu_mio_d   = 1'b0;
            mem_w_d     = 1'b0;
            be_d        = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      cnt_q       <= '0;
      cpu_mio_q   <= 1'b0;
      mem_w_q     <= 1'b0;
      addr_q      <= '0;
      data_out_q  <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      cpu_mio_q   <= cpu_mio_d;
      mem_w_q     <= mem_w_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.CPU_MIO   = cpu_mio_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.Addr_out  = addr_q;
  assign bus.Data_out  = data_out_q;
  assign bus.be_out    = be_q;
endmodule

// File: tb/tb_mio_bus_if.sv
// Bench for mio_bus_if: a 32-bit instance with TIMEOUT=4 and a 64-bit instance
// with the timeout disabled, driven from one stimulus set selected by sel.
module tb_mio_bus_if;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, mio_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, data_in = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mio_bus_if_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
  mio_bus_if_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

  mio_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u32 (.clk(clk), .reset(reset), .bus(b32));
  mio_bus_if #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(0)) u64 (.clk(clk), .reset(reset), .bus(b64));

  assign b32.req_valid  = req_valid & ~sel;
  assign b32.req_we     = req_we;
  assign b32.req_size   = req_size;
  assign b32.req_signed = req_signed;
  assign b32.req_addr   = req_addr;
  assign b32.req_wdata  = req_wdata[31:0];
  assign b32.Data_in    = data_in[31:0];
  assign b32.MIO_ready  = mio_ready & ~sel;
  assign b64.req_valid  = req_valid & sel;
  assign b64.req_we     = req_we;
  assign b64.req_size   = req_size;
  assign b64.req_signed = req_signed;
  assign b64.req_addr   = req_addr;
  assign b64.req_wdata  = req_wdata;
  assign b64.Data_in    = data_in;
  assign b64.MIO_ready  = mio_ready & sel;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_cpu_mio, o_mem_w;
  logic [63:0] o_rdata, o_data_out;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  assign o_req_ready = sel ? b64.req_ready : b32.req_ready;
  assign o_rsp_valid = sel ? b64.rsp_valid : b32.rsp_valid;
  assign o_rsp_err   = sel ? b64.rsp_err   : b32.rsp_err;
  assign o_cpu_mio   = sel ? b64.CPU_MIO   : b32.CPU_MIO;
  assign o_mem_w     = sel ? b64.mem_w     : b32.mem_w;
  assign o_rdata     = sel ? b64.rsp_rdata : {32'b0, b32.rsp_rdata};
  assign o_data_out  = sel ? b64.Data_out  : {32'b0, b32.Data_out};
  assign o_addr      = sel ? b64.Addr_out  : b32.Addr_out;
  assign o_be        = sel ? b64.be_out    : {4'b0, b32.be_out};

  // Reference load result: pick the addressed bytes arithmetically, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] din, input int dw,
                                           input logic [31:0] addr, input logic [1:0] size, input bit sgn);
    logic [127:0] v, lim;
    int nb, ln;
    nb  = 1 << size;
    ln  = int'(addr % 32'(dw / 8));
    v   = 128'(din) >> (8 * ln);
    lim = 128'd1 << (8 * nb);
    v   = v % lim;
    if (sgn && v >= (lim >> 1)) v = v - lim;
    if (dw == 32) return {32'b0, v[31:0]};
    return v[63:0];
  endfunction

  // One request on the selected instance; waits = idle ACCESS cycles before ready.
  task automatic run(input bit s, input bit we, input logic [1:0] size, input bit sgn,
                     input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] din, input int waits);
    int dw, to, nb, ln, ncyc, exp_cyc;
    bit mis, exp_err;
    logic [63:0] mask, exp_rd, exp_do, held_rd;
    logic [7:0]  exp_be;
    logic [31:0] exp_addr;
    dw   = s ? 64 : 32;
    to   = s ? 0 : 4;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    nb   = 1 << size;
    ln   = int'(addr % 32'(dw / 8));
    mis  = (addr % 32'(nb) != 0) || (nb * 8 > dw);
    exp_be   = 8'(((1 << nb) - 1) << ln);
    exp_addr = addr - 32'(ln);
    exp_do   = (wdata << (8 * ln)) & mask;
    exp_rd   = ref_load(din & mask, dw, addr, size, sgn);
    exp_err  = (to != 0) && (waits >= to);
    exp_cyc  = exp_err ? to : waits + 1;

    @(negedge clk);
    sel = s; req_we = we; req_size = size; req_signed = sgn; req_addr = addr;
    req_wdata = wdata; data_in = din; req_valid = 1'b1; mio_ready = 1'($urandom % 2);
    vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL req_ready_idle: got %b want 1", o_req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; mio_ready = 1'b0;

    if (mis) begin
      vectors++; if (o_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mis_rsp_valid: got %b want 1 addr=%h size=%0d", o_rsp_valid, addr, size); end
      vectors++; if (o_rsp_err !== 1'b1) begin miscompares++; $display("FAIL mis_rsp_err: got %b want 1", o_rsp_err); end
      vectors++; if (o_rdata !== 64'd0) begin miscompares++; $display("FAIL mis_rdata: got %h want 0", o_rdata); end
      vectors++; if (o_cpu_mio !== 1'b0) begin miscompares++; $display("FAIL mis_cpu_mio: got %b want 0", o_cpu_mio); end
      @(posedge clk); #1;
      vectors++; if (o_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mis_pulse: got %b want 0", o_rsp_valid); end
      vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL mis_ready_back: got %b want 1", o_req_ready); end
      return;
    end

    ncyc = 0;
    while (o_rsp_valid !== 1'b1 && ncyc < 40) begin
      vectors++; if (o_cpu_mio !== 1'b1) begin miscompares++; $display("FAIL acc_cpu_mio: got %b want 1 cyc=%0d", o_cpu_mio, ncyc); end
      vectors++; if (o_mem_w !== we) begin miscompares++; $display("FAIL acc_mem_w: got %b want %b", o_mem_w, we); end
      vectors++; if (o_be !== exp_be) begin miscompares++; $display("FAIL acc_be: got %h want %h", o_be, exp_be); end
      vectors++; if (o_addr !== exp_addr) begin miscompares++; $display("FAIL acc_addr: got %h want %h", o_addr, exp_addr); end
      vectors++; if (o_data_out !== exp_do) begin miscompares++; $display("FAIL acc_data_out: got %h want %h", o_data_out, exp_do); end
      vectors++; if (o_req_ready !== 1'b0) begin miscompares++; $display("FAIL acc_req_ready: got %b want 0", o_req_ready); end
      mio_ready = (ncyc == waits);
      @(posedge clk); #1;
      mio_ready = 1'b0;
      ncyc++;
    end
    vectors++; if (ncyc !== exp_cyc) begin miscompares++; $display("FAIL access_cycles: got %0d want %0d", ncyc, exp_cyc); end
    vectors++; if (o_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rsp_valid: got %b want 1", o_rsp_valid); end
    vectors++; if (o_rsp_err !== exp_err) begin miscompares++; $display("FAIL rsp_err: got %b want %b", o_rsp_err, exp_err); end
    held_rd = (we || exp_err) ? 64'd0 : exp_rd;
    vectors++; if (o_rdata !== held_rd) begin miscompares++; $display("FAIL rsp_rdata: got %h want %h", o_rdata, held_rd); end
    vectors++; if ({o_cpu_mio, o_mem_w, o_be} !== 10'd0) begin miscompares++; $display("FAIL bus_idle: got %b/%b/%h want 0", o_cpu_mio, o_mem_w, o_be); end
    @(posedge clk); #1;
    vectors++; if (o_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_pulse: got %b want 0", o_rsp_valid); end
    vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_back: got %b want 1", o_req_ready); end
    vectors++; if (o_rdata !== held_rd) begin miscompares++; $display("FAIL rdata_hold: got %h want %h", o_rdata, held_rd); end
    vectors++; if (o_addr !== exp_addr) begin miscompares++; $display("FAIL addr_hold: got %h want %h", o_addr, exp_addr); end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b want 1", o_req_ready); end
      vectors++; if ({o_rsp_valid, o_rsp_err, o_cpu_mio, o_mem_w} !== 4'd0) begin miscompares++; $display("FAIL rst_flags: got %b want 0000", {o_rsp_valid, o_rsp_err, o_cpu_mio, o_mem_w}); end
      vectors++; if ({o_rdata, o_data_out, o_addr, o_be} !== 168'd0) begin miscompares++; $display("FAIL rst_data: got %h/%h/%h/%h want 0", o_rdata, o_data_out, o_addr, o_be); end
    end
    sel = 1'b0;
  endtask

  task automatic test_load_byte();
    run(1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 64'd0, 64'h0000_0000_8012_3456, 0);
  endtask

  task automatic test_store_half();
    run(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 64'h0000_0000_0000_BEEF, 64'h0, 3);
  endtask

  task automatic test_misaligned();
    run(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0001, 64'd0, 64'hFFFF_FFFF, 0);
    run(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 64'd0, 64'hFFFF_FFFF, 0);
    run(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0004, 64'd0, 64'hFFFF_FFFF, 0);
  endtask

  task automatic test_timeout();
    run(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 64'd0, 64'h1234_5678, 4);
    run(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 64'd0, 64'h1234_5678, 3);
    run(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 64'h5A, 64'd0, 7);
  endtask

  task automatic test_dword();
    run(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    run(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_000C, 64'd0, 64'h8123_4567_89AB_CDEF, 10);
    run(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0006, 64'h0000_0000_0000_CAFE, 64'd0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit s;
      logic [1:0]  sz;
      logic [31:0] a;
      s  = (n % 2) == 1;
      sz = 2'($urandom % 4);
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom % 4 != 0) a = a & ~32'((1 << sz) - 1);
      run(s, 1'($urandom % 2), sz, 1'($urandom % 2), a, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom % 6));
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0040; req_wdata = 64'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (o_cpu_mio !== 1'b1) begin miscompares++; $display("FAIL mid_cpu_mio: got %b want 1", o_cpu_mio); end
    reset = 1'b1; #1;
    vectors++; if ({o_cpu_mio, o_mem_w, o_be, o_rsp_valid, o_rsp_err} !== 12'd0) begin miscompares++; $display("FAIL mid_rst_flags: got %b/%b/%h/%b/%b want 0", o_cpu_mio, o_mem_w, o_be, o_rsp_valid, o_rsp_err); end
    vectors++; if ({o_addr, o_data_out, o_rdata} !== 160'd0) begin miscompares++; $display("FAIL mid_rst_data: got %h/%h/%h want 0", o_addr, o_data_out, o_rdata); end
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mio_ready = 1'b1;
      @(posedge clk); #1;
      vectors++; if (o_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_rsp: got %b want 0 cyc=%0d", o_rsp_valid, c); end
      vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b want 1", o_req_ready); end
    end
    mio_ready = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    @(negedge clk); reset = 1'b0;
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_dword();
    test_random();
    test_reset_mid_access();
    test_load_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
